weight_pingpong_buffer: RTL
===========================

Name: weight_pingpong_buffer

Overview:
Double-buffered (ping/pong) weight store with per-bank occupancy tracking and a fill/drain handshake. The loader fills one bank while the PE controller reads the other. Banks swap only when both sides release them. Adds byte-enable writes, a configurable read pipeline with a valid flag, and sticky protocol-error flags.

Parameters:
DATA_WIDTH, 128, weight word width in bits; must be a multiple of 8.
ADDR_WIDTH, 12, word address width per bank.
DEPTH, 4096, words per bank; DEPTH <= 2**ADDR_WIDTH.
OUT_REG, 1, extra output register stage: 0 or 1.
(derived) BE_WIDTH = DATA_WIDTH/8.

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
wr_en  in  1  write strobe into the fill bank.
wr_addr  in  ADDR_WIDTH  write word address.
wr_data  in  DATA_WIDTH  write data.
wr_be  in  BE_WIDTH  byte enables; bit i covers bits [8i+7:8i].
wr_done  in  1  pulse: loader has finished the fill bank.
wr_ready  out  1  fill bank is free (empty) and accepts writes.
rd_en  in  1  read request from the drain bank.
rd_addr  in  ADDR_WIDTH  read word address.
rd_data  out  DATA_WIDTH  read data.
rd_valid  out  1  rd_data is valid this cycle.
rd_done  in  1  pulse: controller has finished the drain bank.
rd_ready  out  1  drain bank is full and readable.
fill_bank  out  1  index of the current fill bank.
drain_bank  out  1  index of the current drain bank.
err_clr  in  1  clears the sticky error flags.
err_wr  out  1  sticky: write or wr_done attempted while wr_ready=0, or wr_addr >= DEPTH.
err_rd  out  1  sticky: read or rd_done attempted while rd_ready=0, or rd_addr >= DEPTH.

Behaviour:
- State: full[1:0], fill_ptr, drain_ptr.
  - wr_ready = !full[fill_ptr].
  - rd_ready = full[drain_ptr].
  - fill_bank = fill_ptr; drain_bank = drain_ptr.
- Reset (async, rst_n=0): full=00, both pointers 0, rd_valid=0, rd_data=0, err_wr=0, err_rd=0.
  - Memory contents are not reset.
  - Reset mid-transfer discards all occupancy and in-flight reads.
- Write accept: wr_en && wr_ready && wr_addr<DEPTH.
  - Only enabled bytes of bank[fill_ptr][wr_addr] update at the clock edge.
  - wr_be=0 performs no update.
  - Any other wr_en is dropped and sets err_wr.
- wr_done with wr_ready=1: full[fill_ptr]<=1 and fill_ptr toggles.
  - A write in the same cycle is applied to the old fill bank first.
  - wr_done with wr_ready=0 is ignored and sets err_wr.
- Read accept: rd_en && rd_ready && rd_addr<DEPTH.
  - The memory is read at that edge.
  - rd_valid=1 and rd_data are presented exactly 1+OUT_REG cycles after the accept cycle.
  - Full throughput: one read per cycle.
  - rd_valid=0 when nothing was accepted; rd_data then holds its last value.
  - A rejected rd_en sets err_rd and produces no rd_valid.
  - Out-of-range rd_addr sets err_rd.
- rd_done with rd_ready=1: full[drain_ptr]<=0 and drain_ptr toggles.
  - A read in the same cycle uses the old bank; reads already in flight complete normally.
  - rd_done with rd_ready=0 is ignored and sets err_rd.
- Simultaneous wr_done and rd_done: both are evaluated against pre-edge state and both apply.
  - When fill_ptr==drain_ptr only one can be legal, since the bank is either empty or full.
- Both banks full: wr_ready=0 until rd_done. Both empty: rd_ready=0 until wr_done.
- Fill and drain are never the same bank while both are active, so there is no read/write address collision.
- err_clr clears both flags. If a new error occurs in the same cycle, the new error wins (the flag is set).

Test Plan:
1. Reset, then write addr 0..3 with data 0x1000+i, be all ones, then wr_done → wr_ready=0 for 0 cycles (bank1 empty), rd_ready=1, drain_bank=0. Read addr 2 → rd_valid and 0x1002 after 2 cycles (OUT_REG=1), and after 1 cycle with OUT_REG=0.
2. Word 5 = 0xFFFF..FF; write 0x00 with wr_be=0x0001 → read returns 0xFFFF..FF00.
3. Fill both banks with no rd_done → wr_ready=0. Further wr_en sets err_wr and leaves memory unchanged. rd_done → wr_ready=1, fill_bank=0.
4. Back-to-back reads of addr 0..7 with rd_done asserted with the last rd_en → 8 consecutive rd_valid pulses with correct data. rd_ready then drops and drain_bank toggles.
5. rd_en while both banks are empty → no rd_valid, err_rd=1. err_clr → err_rd=0. wr_addr=DEPTH → err_wr=1, no write.
6. Assert rst_n=0 with reads in flight → rd_valid=0 immediately, full=00, pointers 0. No rd_valid after release.

Source files
------------

// File: rtl/weight_pingpong_buffer.sv
// weight_pingpong_buffer: ping/pong weight store; the loader fills one bank while the PE side drains the other,
// and banks swap only on wr_done/rd_done handshakes. Byte-enable writes, pipelined reads, sticky error flags.
module weight_pingpong_buffer #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH = 4096,
    parameter int OUT_REG = 1,
    localparam int BE_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BE_WIDTH-1:0]   wr_be,
    input  logic                  wr_done,
    output logic                  wr_ready,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_done,
    output logic                  rd_ready,
    output logic                  fill_bank,
    output logic                  drain_bank,
    input  logic                  err_clr,
    output logic                  err_wr,
    output logic                  err_rd
);
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
    logic [DATA_WIDTH-1:0] mem [2][DEPTH];
    logic [DATA_WIDTH-1:0] rd_mem;
    logic [1:0] full;
    logic fill_ptr, drain_ptr, rd_v1;
    logic wr_acc, rd_acc, wr_fin, rd_fin;
    assign wr_ready   = !full[fill_ptr];
    assign rd_ready   = full[drain_ptr];
    assign fill_bank  = fill_ptr;
    assign drain_bank = drain_ptr;
    assign wr_acc = wr_en && wr_ready && ({1'b0, wr_addr} < LIMIT);
    assign rd_acc = rd_en && rd_ready && ({1'b0, rd_addr} < LIMIT);
    assign wr_fin = wr_done && wr_ready;
    assign rd_fin = rd_done && rd_ready;
    // set and clear masks both come from pre-edge state, so simultaneous handshakes both land
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= 2'b00;
            fill_ptr  <= 1'b0;
            drain_ptr <= 1'b0;
            err_wr    <= 1'b0;
            err_rd    <= 1'b0;
        end else begin
            full      <= (full | (wr_fin ? 2'b01 << fill_ptr : 2'b00)) & ~(rd_fin ? 2'b01 << drain_ptr : 2'b00);
            fill_ptr  <= fill_ptr ^ wr_fin;
            drain_ptr <= drain_ptr ^ rd_fin;
            err_wr    <= (wr_en && !wr_acc) || (wr_done && !wr_ready) || (err_wr && !err_clr);
            err_rd    <= (rd_en && !rd_acc) || (rd_done && !rd_ready) || (err_rd && !err_clr);
        end
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_WIDTH; i++)
            if (wr_acc && wr_be[i]) mem[fill_ptr][wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1  <= 1'b0;
            rd_mem <= '0;
        end else begin
            rd_v1 <= rd_acc;
            if (rd_acc) rd_mem <= mem[drain_ptr][rd_addr];
        end
    end
    generate
        if (OUT_REG != 0) begin : g_oreg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= rd_v1;
                    if (rd_v1) rd_data <= rd_mem;
                end
            end
        end else begin : g_noreg
            assign rd_valid = rd_v1;
            assign rd_data  = rd_mem;
        end
    endgenerate
endmodule
